// File: rtl/aes_pkg.sv
// Shared AES types and constants: block width, round counts per key size,
// engine state encoding, and the S-box / GF(2^8) helpers used by the round logic.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } engine_state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round; the final round skips MixColumns.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] round_key,
    input  logic                   is_final,
    output logic [AES_BLOCK_W-1:0] next_state
);

    logic [AES_BLOCK_W-1:0] subbed;
    logic [AES_BLOCK_W-1:0] shifted;
    logic [AES_BLOCK_W-1:0] mixed;

    sbox_layer u_sbox (
        .block  (state),
        .result (subbed)
    );

    shift_rows u_shift (
        .block  (subbed),
        .result (shifted)
    );

    mix_columns u_mix (
        .block  (shifted),
        .result (mixed)
    );

    assign next_state = (is_final ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each 32-bit column is multiplied by the fixed {02,03,01,01} circulant.
module mix_columns
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] block,
    output logic [AES_BLOCK_W-1:0] result
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;

        assign a0 = block[127 - 32*gi -: 8];
        assign a1 = block[119 - 32*gi -: 8];
        assign a2 = block[111 - 32*gi -: 8];
        assign a3 = block[103 - 32*gi -: 8];

        // 03*a is xtime(a)^a
        assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

        assign result[127 - 32*gi -: 32] = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/sbox_layer.sv
// SubBytes: applies the AES S-box independently to all 16 bytes of a block.
module sbox_layer
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] block,
    output logic [AES_BLOCK_W-1:0] result
);

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        assign result[8*gi +: 8] = sbox(block[8*gi +: 8]);
    end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: byte i of the block is row i%4, column i/4; row r rotates left by r.
module shift_rows
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] block,
    output logic [AES_BLOCK_W-1:0] result
);

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
        assign result[127 - 8*gi -: 8] = block[127 - 8*SRC -: 8];
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: initial AddRoundKey on accept, then NR rounds.
// Optional macro AES_EARLY_ACCEPT_EN lets a new block enter on the output handshake edge.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR       = AES128_NR,
    parameter int RK_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic [RK_IDX_W-1:0]    rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    if (!(NR == AES128_NR || NR == AES192_NR || NR == AES256_NR)) begin : g_bad_nr
        $error("aes_round_engine: NR must be 10, 12 or 14");
    end
    if ((2 ** RK_IDX_W) <= NR) begin : g_bad_idx_w
        $error("aes_round_engine: RK_IDX_W too narrow to index round NR");
    end

    localparam logic [RK_IDX_W-1:0] LAST_ROUND = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] FIRST_ROUND = RK_IDX_W'(1);

    engine_state_t          fsm_reg, fsm_next;
    logic [AES_BLOCK_W-1:0] state_reg, state_next;
    logic [RK_IDX_W-1:0]    round_cnt, round_cnt_next;
    logic [AES_BLOCK_W-1:0] round_out;
    logic                   is_final;

    assign is_final = (round_cnt == LAST_ROUND);

    aes_round_comb u_round (
        .state      (state_reg),
        .round_key  (rk_data),
        .is_final   (is_final),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            round_cnt <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            round_cnt <= round_cnt_next;
        end
    end

    // rk_idx depends only on registered state so the key store may be a plain ROM.
    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        round_cnt_next = round_cnt;
        in_ready       = 1'b0;
        busy           = 1'b0;
        out_valid      = 1'b0;
        out_block      = '0;
        rk_idx         = '0;

        case (fsm_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next     = in_block ^ rk_data;
                    round_cnt_next = FIRST_ROUND;
                    fsm_next       = ROUND;
                end
            end

            ROUND: begin
                busy       = 1'b1;
                rk_idx     = round_cnt;
                state_next = round_out;
                if (is_final) begin
                    fsm_next = DONE;
                end else begin
                    round_cnt_next = round_cnt + FIRST_ROUND;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                out_block = state_reg;
`ifdef AES_EARLY_ACCEPT_EN
                in_ready  = out_ready;
`else
                in_ready  = 1'b0;
`endif
                if (out_ready) begin
                    fsm_next       = IDLE;
                    round_cnt_next = '0;
`ifdef AES_EARLY_ACCEPT_EN
                    if (in_valid) begin
                        state_next     = in_block ^ rk_data;
                        round_cnt_next = FIRST_ROUND;
                        fsm_next       = ROUND;
                    end
`endif
                end
            end

            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine at NR=10/12/14 with a key-expansion model
// serving rk_data; known-answer vectors from FIPS-197.
module tb_aes_round_engine;

    localparam int NU = 3;
`ifdef AES_EARLY_ACCEPT_EN
    localparam int SPACING = 11;
`else
    localparam int SPACING = 12;
`endif

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [127:0] blk;
        int           due;
    } exp_t;

    typedef struct {
        int           u;
        int           cyc;
        int           kind;
        logic [134:0] exp;
        string        name;
    } probe_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NU];
    logic         in_ready  [NU];
    logic [127:0] in_block  [NU];
    logic [3:0]   rk_idx    [NU];
    logic [127:0] rk_data   [NU];
    logic         out_valid [NU];
    logic         out_ready [NU];
    logic [127:0] out_block [NU];
    logic         busy      [NU];

    logic [127:0] rks [4][16];
    int           ksel [NU];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           done = 1'b0;

    exp_t         exp_q [NU][$];
    probe_t       probe_q [$];
    int           trace [NU];
    bit           seen [NU];
    int           acc_prev [NU];
    int           acc_last [NU];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        aes_round_engine #(.NR(10 + 2*gi), .RK_IDX_W(4)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_block  (in_block[gi]),
            .rk_idx    (rk_idx[gi]),
            .rk_data   (rk_data[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_block (out_block[gi]),
            .busy      (busy[gi])
        );
        assign rk_data[gi] = rks[ksel[gi]][rk_idx[gi]];
    end

    // ---------------- key expansion model ----------------
    function automatic logic [7:0] tsb(input logic [7:0] x);
        return TB_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tsb(w[31:24]), tsb(w[23:16]), tsb(w[15:8]), tsb(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int slot);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rks[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rks[slot][r] = '0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int u, input logic [134:0] got, input logic [134:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s u=%0d cyc=%0d got=%h want=%h", name, u, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        probe_t       pr;
        exp_t         e;
        logic [134:0] act;
        if (!rst) begin
            while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
                pr = probe_q.pop_front();
                if (pr.kind == 0)
                    act = {in_ready[pr.u], busy[pr.u], out_valid[pr.u], rk_idx[pr.u], out_block[pr.u]};
                else
                    act = 135'(acc_last[pr.u] - acc_prev[pr.u]);
                chk(pr.name, pr.u, act, pr.exp);
            end
        end
        for (int u = 0; u < NU; u++) begin
            if (rst) begin
                exp_q[u].delete();
                trace[u] = 0;
                seen[u]  = 1'b0;
            end else begin
                if (in_valid[u] && in_ready[u]) begin
                    chk("rk_idx_accept", u, 135'(rk_idx[u]), 135'(0));
                    trace[u]    = 1;
                    acc_prev[u] = acc_last[u];
                    acc_last[u] = cyc;
                end else if (trace[u] != 0) begin
                    chk("rk_idx_trace", u, 135'(rk_idx[u]), 135'(trace[u]));
                    trace[u] = (trace[u] == 10 + 2*u) ? 0 : trace[u] + 1;
                end
                if (out_valid[u]) begin
                    if (exp_q[u].size() == 0) begin
                        chk("unexpected_out", u, 135'(1), 135'(0));
                    end else begin
                        e = exp_q[u][0];
                        if (!seen[u]) chk("latency", u, 135'(cyc), 135'(e.due));
                        seen[u] = 1'b1;
                        chk("ciphertext", u, 135'(out_block[u]), 135'(e.blk));
                        if (out_ready[u]) begin
                            void'(exp_q[u].pop_front());
                            seen[u] = 1'b0;
                        end
                    end
                end else begin
                    seen[u] = 1'b0;
                end
            end
        end
        if (done) begin
            for (int u = 0; u < NU; u++)
                chk("leftover_expected", u, 135'(exp_q[u].size()), 135'(0));
            chk("leftover_probes", 0, 135'(probe_q.size()), 135'(0));
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int u, input logic [127:0] pt, input logic [127:0] ct);
        int n;
        @(posedge clk); #1;
        in_valid[u] = 1'b1;
        in_block[u] = pt;
        n = 0;
        @(negedge clk);
        while (!in_ready[u]) begin
            n++;
            if (n > 40) begin
                $display("FAIL send_timeout u=%0d got=in_ready_low want=accept", u);
                $fatal(1);
            end
            @(negedge clk);
        end
        $display("send u=%0d pt=%h expect=%h accept_cyc=%0d", u, pt, ct, cyc);
        exp_q[u].push_back('{blk: ct, due: cyc + 10 + 2*u + 1});
    endtask

    task automatic send_one(input int u, input logic [127:0] pt, input logic [127:0] ct);
        send(u, pt, ct);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic probe(input int u, input string name, input logic ir, input logic bz,
                         input logic ov, input logic [3:0] rk, input logic [127:0] blk);
        probe_q.push_back('{u: u, cyc: cyc, kind: 0, exp: {ir, bz, ov, rk, blk}, name: name});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            in_valid[u]  = 1'b0;
            in_block[u]  = '0;
            out_ready[u] = 1'b1;
            ksel[u]      = u;
            trace[u]     = 0;
            seen[u]      = 1'b0;
            acc_prev[u]  = 0;
            acc_last[u]  = 0;
        end
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 0);
        expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 1);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 2);
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 3);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int u = 0; u < NU; u++) probe(u, "reset_state", 1'b1, 1'b0, 1'b0, 4'd0, 128'h0);

        // known-answer vectors for each key size
        send_one(0, PT_C, CT_128);
        send_one(1, PT_C, CT_192);
        send_one(2, PT_C, CT_256);
        repeat (20) @(posedge clk);

        ksel[0] = 3;
        send_one(0, PT_B, CT_B);
        repeat (16) @(posedge clk);
        ksel[0] = 0;

        // backpressure in DONE with a competing input request
        out_ready[0] = 1'b0;
        send_one(0, PT_C, CT_128);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid[0]) break;
        end
        if (n == 40) begin
            $display("FAIL wait_out_valid got=timeout want=out_valid");
            $fatal(1);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid[0] = 1'b1;
            in_block[0] = PT_B;
            probe(0, "backpressure_hold", 1'b0, 1'b0, 1'b1, 4'd0, CT_128);
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        repeat (4) @(posedge clk);

        // reset while rk_idx==5
        send_one(0, PT_C, CT_128);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rk_idx[0] == 4'd4) break;
        end
        if (n == 40) begin
            $display("FAIL wait_rk_idx got=timeout want=rk_idx_4");
            $fatal(1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        probe(0, "after_abort", 1'b1, 1'b0, 1'b0, 4'd0, 128'h0);
        send_one(0, PT_C, CT_128);
        repeat (16) @(posedge clk);

        // back-to-back with in_valid held high
        send(0, PT_C, CT_128);
        send(0, PT_C, CT_128);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        probe_q.push_back('{u: 0, cyc: cyc, kind: 1, exp: 135'(SPACING), name: "accept_spacing"});
        repeat (20) @(posedge clk);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_stalled got=no_summary want=summary");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
